// File: rtl/cv32e40p_tmr_pmp_scrubber.sv
// Triplicated PMP entry storage with CSR write fan-out and a background majority-vote scrubber.
// Optional fault-injection ports are enabled by defining CV32E40P_TMR_FAULT_INJ_EN.
module cv32e40p_tmr_pmp_scrubber #(
  parameter int WIDTH         = 32,
  parameter int N_PMP_ENTRIES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      we_i,
  input  logic [$clog2(N_PMP_ENTRIES)-1:0]          waddr_i,
  input  logic [WIDTH-1:0]                          wdata_i,
  input  logic                                      scrub_en_i,
  input  logic                                      err_clr_i,
`ifdef CV32E40P_TMR_FAULT_INJ_EN
  input  logic                                      inj_en_i,
  input  logic [1:0]                                inj_rep_i,
  input  logic [$clog2(N_PMP_ENTRIES)-1:0]          inj_idx_i,
  input  logic [WIDTH-1:0]                          inj_mask_i,
`endif
  output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]       rep1_o,
  output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]       rep2_o,
  output logic [N_PMP_ENTRIES-1:0][WIDTH-1:0]       rep3_o,
  output logic                                      err_det_o,
  output logic [CNT_W-1:0]                          err_cnt_o,
  output logic                                      sweep_done_o,
  output logic [$clog2(N_PMP_ENTRIES)-1:0]          scrub_idx_o
);

  localparam int IDX_W = $clog2(N_PMP_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PMP_ENTRIES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SCAN, REPAIR} state_e;

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [WIDTH-1:0]                   fix_q, fix_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               det_q, det_d;
  logic                               done_q, done_d;
  logic [N_PMP_ENTRIES-1:0][WIDTH-1:0] rep_q [3];
  logic [N_PMP_ENTRIES-1:0][WIDTH-1:0] rep_d [3];

  logic             inj_act;
  logic [1:0]       inj_rep;
  logic [IDX_W-1:0] inj_idx;
  logic [WIDTH-1:0] inj_mask;

`ifdef CV32E40P_TMR_FAULT_INJ_EN
  assign inj_act  = inj_en_i && (inj_rep_i != 2'd0);
  assign inj_rep  = inj_rep_i;
  assign inj_idx  = inj_idx_i;
  assign inj_mask = inj_mask_i;
`else
  assign inj_act  = 1'b0;
  assign inj_rep  = 2'd0;
  assign inj_idx  = '0;
  assign inj_mask = '0;
`endif

  logic [WIDTH-1:0] cur_a, cur_b, cur_c, maj;
  logic             mismatch;
  logic             fix_we;
  logic             cnt_inc;

  assign cur_a    = rep_q[0][idx_q];
  assign cur_b    = rep_q[1][idx_q];
  assign cur_c    = rep_q[2][idx_q];
  assign maj      = (cur_a & cur_b) | (cur_a & cur_c) | (cur_b & cur_c);
  assign mismatch = (cur_a != cur_b) || (cur_a != cur_c);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fix_d   = fix_q;
    det_d   = 1'b0;
    done_d  = 1'b0;
    fix_we  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scrub_en_i) state_d = SCAN;
      end
      SCAN: begin
        if (!scrub_en_i) begin
          state_d = IDLE;
        end else if (mismatch) begin
          fix_d   = maj;
          det_d   = 1'b1;
          state_d = REPAIR;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          done_d = (idx_q == LAST_IDX);
        end
      end
      REPAIR: begin
        // A CSR write landing on the same entry supersedes the voted value.
        if (!(we_i && (waddr_i == idx_q))) begin
          fix_we  = 1'b1;
          cnt_inc = 1'b1;
        end
        idx_d   = idx_q + IDX_W'(1);
        done_d  = (idx_q == LAST_IDX);
        state_d = scrub_en_i ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i)                      cnt_d = '0;
    else if (cnt_inc && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // Write priority on one entry: CSR write > scrub repair > fault injection.
  always_comb begin
    for (int r = 0; r < 3; r++) rep_d[r] = rep_q[r];
    for (int r = 0; r < 3; r++) begin
      if (inj_act && (inj_rep == 2'(r + 1))) rep_d[r][inj_idx] = rep_q[r][inj_idx] ^ inj_mask;
    end
    if (fix_we) begin
      for (int r = 0; r < 3; r++) rep_d[r][idx_q] = fix_q;
    end
    if (we_i) begin
      for (int r = 0; r < 3; r++) rep_d[r][waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fix_q   <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < 3; r++) rep_q[r] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fix_q   <= fix_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      done_q  <= done_d;
      for (int r = 0; r < 3; r++) rep_q[r] <= rep_d[r];
    end
  end

  assign rep1_o       = rep_q[0];
  assign rep2_o       = rep_q[1];
  assign rep3_o       = rep_q[2];
  assign err_det_o    = det_q;
  assign err_cnt_o    = cnt_q;
  assign sweep_done_o = done_q;
  assign scrub_idx_o  = idx_q;

endmodule

// File: tb/tb_cv32e40p_tmr_pmp_scrubber.sv
// Randomized bench for cv32e40p_tmr_pmp_scrubber with an entry-level behavioural model.
// Injection scenarios run when CV32E40P_TMR_FAULT_INJ_EN is defined.
module tb_cv32e40p_tmr_pmp_scrubber;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int CNT_W = 4;
  localparam int IW    = 4;
  localparam int CW    = N * WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                       we;
  logic [IW-1:0]              waddr;
  logic [WIDTH-1:0]           wdata;
  logic                       scrub_en;
  logic                       err_clr;
  logic [N-1:0][WIDTH-1:0]    rep1, rep2, rep3;
  logic                       err_det;
  logic [CNT_W-1:0]           err_cnt;
  logic                       sweep_done;
  logic [IW-1:0]              scrub_idx;
`ifdef CV32E40P_TMR_FAULT_INJ_EN
  logic                       inj_en;
  logic [1:0]                 inj_rep;
  logic [IW-1:0]              inj_idx;
  logic [WIDTH-1:0]           inj_mask;
`endif

  cv32e40p_tmr_pmp_scrubber #(.WIDTH(WIDTH), .N_PMP_ENTRIES(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .scrub_en_i   (scrub_en),
    .err_clr_i    (err_clr),
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    .inj_en_i     (inj_en),
    .inj_rep_i    (inj_rep),
    .inj_idx_i    (inj_idx),
    .inj_mask_i   (inj_mask),
`endif
    .rep1_o       (rep1),
    .rep2_o       (rep2),
    .rep3_o       (rep3),
    .err_det_o    (err_det),
    .err_cnt_o    (err_cnt),
    .sweep_done_o (sweep_done),
    .scrub_idx_o  (scrub_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int det_seen = 0;

  // behavioural model: storage as plain arrays, scanner as position + pending flag
  logic [WIDTH-1:0] m_rep [3][N];
  int               m_idx;
  bit               m_active;
  bit               m_pending;
  logic [WIDTH-1:0] m_fix;
  bit               m_det;
  bit               m_done;
  int               m_cnt;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) m_rep[r][i] = '0;
    m_idx = 0; m_active = 0; m_pending = 0; m_fix = '0;
    m_det = 0; m_done = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [WIDTH-1:0] a, b, c, vote;
    bit do_fix, inc, det, done, nxt_pending, nxt_active;
    int nidx, ones;
    a = m_rep[0][m_idx]; b = m_rep[1][m_idx]; c = m_rep[2][m_idx];
    do_fix = 0; inc = 0; det = 0; done = 0; nxt_pending = 0; nxt_active = m_active;
    nidx = m_idx;
    if (m_pending) begin
      if (!(we && int'(waddr) == m_idx)) begin do_fix = 1; inc = 1; end
      nidx = (m_idx + 1) % N;
      done = (m_idx == N - 1);
      nxt_active = scrub_en;
    end else if (m_active) begin
      if (!scrub_en) begin
        nxt_active = 0;
      end else if (a != b || b != c) begin
        for (int k = 0; k < WIDTH; k++) begin
          ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
          vote[k] = (ones >= 2);
        end
        nxt_pending = 1;
        det = 1;
      end else begin
        nidx = (m_idx + 1) % N;
        done = (m_idx == N - 1);
      end
    end else begin
      nxt_active = scrub_en;
    end
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    if (inj_en && inj_rep != 2'd0)
      m_rep[int'(inj_rep) - 1][inj_idx] = m_rep[int'(inj_rep) - 1][inj_idx] ^ inj_mask;
`endif
    if (do_fix) for (int r = 0; r < 3; r++) m_rep[r][m_idx] = m_fix;
    if (we) for (int r = 0; r < 3; r++) m_rep[r][waddr] = wdata;
    if (err_clr) m_cnt = 0;
    else if (inc && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (det) m_fix = vote;
    m_idx = nidx; m_pending = nxt_pending; m_active = nxt_active;
    m_det = det; m_done = done;
  endtask

  task automatic compare_all();
    logic [N-1:0][WIDTH-1:0] e0, e1, e2;
    for (int i = 0; i < N; i++) begin
      e0[i] = m_rep[0][i]; e1[i] = m_rep[1][i]; e2[i] = m_rep[2][i];
    end
    chk("rep1", rep1, e0);
    chk("rep2", rep2, e1);
    chk("rep3", rep3, e2);
    chk("err_det", CW'(err_det), CW'(m_det));
    chk("sweep_done", CW'(sweep_done), CW'(m_done));
    chk("err_cnt", CW'(err_cnt), CW'(m_cnt));
    chk("scrub_idx", CW'(scrub_idx), CW'(m_idx));
  endtask

  // compare process: outputs vs model, then advance model with inputs sampled next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      compare_all();
      if (err_det) det_seen++;
      model_step();
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic write_entry(input int a, input logic [WIDTH-1:0] d);
    we = 1'b1; waddr = IW'(a); wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!sweep_done && cyc < 100);
    if (!sweep_done) timeout("wait_done");
  endtask

`ifdef CV32E40P_TMR_FAULT_INJ_EN
  task automatic pause_scrub();
    scrub_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic inject(input int r, input int i, input logic [WIDTH-1:0] m);
    inj_en = 1'b1; inj_rep = 2'(r); inj_idx = IW'(i); inj_mask = m;
    tick();
    inj_en = 1'b0;
  endtask

  task automatic one_repair(input int i);
    int k;
    pause_scrub();
    inject(2, i, $urandom | 32'h1);
    scrub_en = 1'b1;
    k = 0;
    while (!err_det && k < 60) begin tick(); k++; end
    if (!err_det) timeout("wait_det");
    tick();
  endtask
`endif

  initial begin
    logic [N-1:0][WIDTH-1:0] t;
    int c, d0, k;
    we = 0; waddr = '0; wdata = '0; scrub_en = 0; err_clr = 0;
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    inj_en = 0; inj_rep = '0; inj_idx = '0; inj_mask = '0;
`endif
    apply_reset();

    chk("rst_rep1", rep1, '0);
    chk("rst_rep3", rep3, '0);
    chk("rst_cnt", CW'(err_cnt), '0);
    chk("rst_idx", CW'(scrub_idx), '0);

    write_entry(3, 32'hDEADBEEF);
    chk("wr_rep1_3", CW'(rep1[3]), CW'(32'hDEADBEEF));
    chk("wr_rep2_3", CW'(rep2[3]), CW'(32'hDEADBEEF));
    chk("wr_rep3_3", CW'(rep3[3]), CW'(32'hDEADBEEF));
    t = rep2; t[3] = '0;
    chk("wr_others", t, '0);
    chk("wr_cnt", CW'(err_cnt), '0);

    write_entry(10, 32'h0BADF00D);
    scrub_en = 1'b1;
    wait_done(c);
    d0 = det_seen;
    wait_done(c);
    chk("clean_period", CW'(c), CW'(16));
    wait_done(c);
    chk("clean_period2", CW'(c), CW'(16));
    chk("clean_no_det", CW'(det_seen - d0), '0);

`ifdef CV32E40P_TMR_FAULT_INJ_EN
    scrub_en = 1'b0;
    apply_reset();
    write_entry(5, 32'hA5A5A5A5);
    scrub_en = 1'b1;
    wait_done(c);
    d0 = det_seen;
    inject(2, 5, 32'h1);
    wait_done(c);
    chk("inj_sweep_len", CW'(c + 1), CW'(17));
    chk("inj_det_pulses", CW'(det_seen - d0), CW'(1));
    chk("inj_rep2_5", CW'(rep2[5]), CW'(32'hA5A5A5A5));
    chk("inj_cnt", CW'(err_cnt), CW'(1));

    pause_scrub();
    inject(1, 0, 32'h0F);
    inject(3, 0, 32'hF0);
    chk("pre_rep1_0", CW'(rep1[0]), CW'(32'h0F));
    scrub_en = 1'b1;
    wait_done(c);
    wait_done(c);
    chk("maj_rep1_0", CW'(rep1[0]), '0);
    chk("maj_rep3_0", CW'(rep3[0]), '0);
    chk("maj_cnt", CW'(err_cnt), CW'(2));

    pause_scrub();
    inject(1, 7, 32'h1);
    scrub_en = 1'b1;
    k = 0;
    while (!(err_det && scrub_idx == IW'(7)) && k < 60) begin tick(); k++; end
    if (!(err_det && scrub_idx == IW'(7))) begin
      timeout("wait_det7");
    end else begin
      write_entry(7, 32'h1234);
      chk("col_rep1_7", CW'(rep1[7]), CW'(32'h1234));
      chk("col_rep2_7", CW'(rep2[7]), CW'(32'h1234));
      chk("col_rep3_7", CW'(rep3[7]), CW'(32'h1234));
      chk("col_cnt", CW'(err_cnt), CW'(2));
    end

    for (int it = 0; it < 16; it++) one_repair(9);
    chk("sat_cnt", CW'(err_cnt), CW'(CMAX));
    one_repair(11);
    chk("sat_hold", CW'(err_cnt), CW'(CMAX));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", CW'(err_cnt), '0);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        we = 1'b0; err_clr = 1'b0;
        apply_reset();
      end
      we       = ($urandom_range(0, 3) == 0);
      waddr    = ($urandom_range(0, 3) == 0) ? scrub_idx : IW'($urandom_range(0, N - 1));
      wdata    = $urandom;
      scrub_en = ($urandom_range(0, 19) != 0);
      err_clr  = ($urandom_range(0, 49) == 0);
`ifdef CV32E40P_TMR_FAULT_INJ_EN
      inj_en   = ($urandom_range(0, 5) == 0);
      inj_rep  = 2'($urandom_range(0, 3));
      inj_idx  = IW'($urandom_range(0, N - 1));
      inj_mask = ($urandom_range(0, 1) == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
`endif
      tick();
    end
    we = 1'b0; err_clr = 1'b0; scrub_en = 1'b0;
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    inj_en = 1'b0;
`endif
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_pmp_scrubber.md
# cv32e40p_tmr_pmp_scrubber

Owns the triplicated PMP configuration/address storage: accepts single-copy writes from the CSR side, fans each write out into three replicas, and runs a background scrubber that walks every entry, bitwise-majority-votes the three copies and rewrites any divergent copy. The three replica buses feed the downstream 2D TMR voter. This block is the write/maintenance end of that voter.

## Interface
- WIDTH, 32, bits per entry
- N_PMP_ENTRIES, 16, number of entries (power of two, ≥2)
- CNT_W, 16, width of the error counter

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- we_i  in  1  CSR write strobe
- waddr_i  in  $clog2(N_PMP_ENTRIES)  write entry index
- wdata_i  in  WIDTH  write data
- scrub_en_i  in  1  enable background scrubbing
- err_clr_i  in  1  synchronous clear of err_cnt_o
- rep1_o, rep2_o, rep3_o  out  [N_PMP_ENTRIES-1:0][WIDTH-1:0]  replica contents, registered
- err_det_o  out  1  one-cycle pulse: mismatch detected on scanned entry
- err_cnt_o  out  CNT_W  repaired-entry count, saturating
- sweep_done_o  out  1  one-cycle pulse at end of each full sweep
- scrub_idx_o  out  $clog2(N_PMP_ENTRIES)  entry currently being scanned

## Operation
- Storage: three register arrays, one per replica; rep*_o drive them directly.
- CSR write: when we_i=1, all three copies of entry waddr_i take wdata_i at the next edge. Always accepted, never stalled.
- FSM states: IDLE, SCAN, REPAIR.
  - IDLE: scrub_en_i=1 → SCAN. idx holds.
  - SCAN: compare the three copies of entry idx. All equal → idx+1, stay SCAN. Any difference → latch bitwise majority (a&b | a&c | b&c) into fix register, pulse err_det_o, → REPAIR (idx holds).
  - REPAIR: write fix value into all three copies of idx, increment err_cnt_o, idx+1, → SCAN.
  - scrub_en_i=0 in SCAN → IDLE; in REPAIR the repair completes, then → IDLE.
- idx wraps N_PMP_ENTRIES-1 → 0; sweep_done_o pulses in the cycle idx advances from N_PMP_ENTRIES-1.
- Collision: we_i to the same index as a pending REPAIR → CSR write wins, repair is dropped (no counter increment), idx still advances. we_i in SCAN to idx → the compare that cycle uses pre-write contents; a detected mismatch is then repaired only if no new write targets idx in REPAIR.
- err_cnt_o saturates at 2^CNT_W-1. err_clr_i clears to 0; clear and increment in the same cycle → 0.

## Timing
- Reset: all replicas 0, idx 0, state IDLE, fix 0, err_cnt_o 0, err_det_o 0, sweep_done_o 0, scrub_idx_o 0.
- Write latency: rep*_o reflect wdata_i one cycle after we_i sampled.
- Clean entry: 1 cycle per entry; full clean sweep N_PMP_ENTRIES cycles.
- Dirty entry: 2 cycles; corrected value visible on rep*_o at edge ending REPAIR.
- err_det_o asserted in the SCAN cycle's following edge (registered), coincident with state=REPAIR.
- Reset deasserted mid-sweep: restart from idx 0 in IDLE; no partial repair survives.

## Configuration
- CV32E40P_TMR_FAULT_INJ_EN defined: adds inputs inj_en_i (1), inj_rep_i (2, replica 1..3), inj_idx_i (index), inj_mask_i (WIDTH); when inj_en_i=1 the selected replica entry is XORed with inj_mask_i at the next edge (CSR write to the same entry takes priority). inj_rep_i=0 ignored.
- Undefined: ports absent, no injection logic; behaviour otherwise identical.

## Test plan
- Reset, write entry 3 = 0xDEADBEEF → next cycle rep1/2/3_o[3] = 0xDEADBEEF, others 0, err_cnt_o=0.
- scrub_en_i=1 with clean storage, N=16 → sweep_done_o pulses every 16 cycles, err_det_o never asserts.
- Inject mask 0x1 into replica 2 entry 5 (entry holds 0xA5A5A5A5) → err_det_o one pulse, rep2_o[5] restored to 0xA5A5A5A5, err_cnt_o=1, that sweep takes 17 cycles.
- Inject different masks 0x0F into rep1 and 0xF0 into rep3 of entry 0 (value 0) → majority 0x00 restored in all copies, err_cnt_o+1.
- Mismatch on entry 7, CSR write 0x1234 to entry 7 during REPAIR → all copies = 0x1234, err_cnt_o unchanged.
- err_cnt_o preloaded to 0xFFFF via repeated repairs (CNT_W=16) → stays 0xFFFF on further repair; err_clr_i → 0.
